// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter: data width default,
// FSM state encoding and a width helper for index signals.
package axis_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   // Minimum of 1 so a select signal always has at least one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so the search starts just after
// last_grant, take the lowest set bit, then rotate the index back.
module rr_pick
   import axis_pkg::*;
#(
   parameter int  N_SRC = 4,
   localparam int GW    = clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [GW-1:0]    last_grant,
   output logic             any_req,
   output logic [GW-1:0]    winner
);

   logic [N_SRC-1:0] rot;
   logic [GW-1:0]    offset;

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_SRC; i++)
         rot[i] = req[GW'((int'(last_grant) + 1 + i) % N_SRC)];
   end

   always_comb begin
      offset = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (rot[i]) offset = GW'(i);
   end

   assign any_req = |req;
   assign winner  = GW'((int'(last_grant) + 1 + int'(offset)) % N_SRC);

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink among N_SRC masters.
// A grant is held until the owner's tlast beat handshakes; one IDLE bubble follows.
module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter int  N_SRC  = 4,
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  CNT_W  = 16,
   localparam int GW     = clog2(N_SRC)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [N_SRC-1:0]        s_tvaild,
   input  logic [N_SRC*DATA_W-1:0] s_tdata,
   input  logic [N_SRC-1:0]        s_tlast,
   output logic [N_SRC-1:0]        s_tready,
   output logic                    m_tvaild,
   output logic [DATA_W-1:0]       m_tdata,
   output logic                    m_tlast,
   input  logic                    m_tready,
   output logic [GW-1:0]           grant_id,
   output logic                    busy,
   output logic                    pkt_done,
   output logic [CNT_W-1:0]        pkt_beats,
   output logic [CNT_W-1:0]        pkt_cnt
);

   state_t           state, state_nxt;
   logic [GW-1:0]    last_grant;
   logic [GW-1:0]    winner;
   logic             any_req;
   logic [CNT_W-1:0] beat_cnt;
   logic             beat;
   logic             last_beat;

   rr_pick #(.N_SRC(N_SRC)) u_pick (
      .req        (s_tvaild),
      .last_grant (last_grant),
      .any_req    (any_req),
      .winner     (winner)
   );

   always_comb begin
      state_nxt = state;
      m_tvaild  = 1'b0;
      m_tdata   = '0;
      m_tlast   = 1'b0;
      s_tready  = '0;
      case (state)
         ST_IDLE: begin
            if (any_req) state_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            // Constant-index mux keeps the pass-through free of variable part-selects.
            for (int i = 0; i < N_SRC; i++) begin
               if (GW'(i) == grant_id) begin
                  m_tvaild    = s_tvaild[i];
                  m_tdata     = s_tdata[i*DATA_W +: DATA_W];
                  m_tlast     = s_tlast[i];
                  s_tready[i] = m_tready;
               end
            end
            if (m_tvaild && m_tready && m_tlast) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign beat      = (state == ST_LOCK) && m_tvaild && m_tready;
   assign last_beat = beat && m_tlast;
   assign busy      = (state == ST_LOCK);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant_id   <= '0;
         last_grant <= GW'(N_SRC - 1);
      end else begin
         if (state == ST_IDLE && any_req) grant_id <= winner;
         if (last_beat) last_grant <= grant_id;
      end
   end

   // Beat counter saturates; a saturated packet reports the saturated count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt  <= '0;
         pkt_beats <= '0;
         pkt_cnt   <= '0;
         pkt_done  <= 1'b0;
      end else begin
         pkt_done <= last_beat;
         if (last_beat) begin
            beat_cnt  <= '0;
            pkt_beats <= (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);
            pkt_cnt   <= pkt_cnt + CNT_W'(1);
         end else if (beat && !(&beat_cnt)) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: AXIS-compliant source queues, a handshake log and
// per-cycle samples compared against hand-derived cycle/data expectations.
module tb_axis_rr_arbiter;
   import axis_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 16;
   localparam int GW = 2;

   logic            clk;
   logic            resetn;
   logic [N-1:0]    s_tvaild;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tlast;
   logic [N-1:0]    s_tready;
   logic            m_tvaild;
   logic [DW-1:0]   m_tdata;
   logic            m_tlast;
   logic            m_tready;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic            pkt_done;
   logic [CW-1:0]   pkt_beats;
   logic [CW-1:0]   pkt_cnt;

   axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_tvaild  (s_tvaild),
      .s_tdata   (s_tdata),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .m_tvaild  (m_tvaild),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .grant_id  (grant_id),
      .busy      (busy),
      .pkt_done  (pkt_done),
      .pkt_beats (pkt_beats),
      .pkt_cnt   (pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            gap;
   } beat_t;

   typedef struct {
      logic [N-1:0]  sready;
      logic          mvalid;
      logic          mlast;
      logic          mready;
      logic          busy;
      logic          done;
      logic [DW-1:0] mdata;
      logic [GW-1:0] gid;
      logic [CW-1:0] beats;
      logic [CW-1:0] cnt;
   } smp_t;

   typedef struct {
      int            cyc;
      logic [GW-1:0] gid;
      logic [DW-1:0] d;
      logic          l;
   } hs_t;

   typedef struct {
      int            cyc;
      logic [CW-1:0] beats;
      logic [CW-1:0] cnt;
   } dn_t;

   beat_t        mem [N][64];
   int           rd [N];
   int           wr [N];
   int           gapc [N];
   smp_t         smp [1024];
   hs_t          hl [128];
   dn_t          dl [32];
   int           n_hl, n_dl, cyc;
   int           n_chk, n_pass;
   logic [N-1:0] hs;
   logic         tog_en;
   int           tog_base;
   int           c0, c1, r0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++)
         if (rd[i] < wr[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_q();
      for (int i = 0; i < N; i++) begin
         rd[i] = 0; wr[i] = 0; gapc[i] = 0;
      end
   endtask

   task automatic push(input int s, input logic [DW-1:0] d, input logic l, input int g);
      mem[s][wr[s]].d   = d;
      mem[s][wr[s]].l   = l;
      mem[s][wr[s]].gap = g;
      if (rd[s] == wr[s]) gapc[s] = g;
      wr[s]++;
   endtask

   task automatic push_pkt(input int s, input int base, input int n);
      for (int b = 0; b < n; b++) push(s, DW'(base + b), (b == n - 1), 0);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (rd[i] < wr[i] && gapc[i] == 0) begin
            s_tvaild[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = mem[i][rd[i]].d;
            s_tlast[i]           = mem[i][rd[i]].l;
         end else begin
            s_tvaild[i]          = 1'b0;
            s_tdata[i*DW +: DW]  = '0;
            s_tlast[i]           = 1'b0;
         end
      end
      m_tready = tog_en ? (((cyc - tog_base) % 2) == 0) : 1'b1;
   endtask

   task automatic sample();
      smp_t v;
      v.sready = s_tready; v.mvalid = m_tvaild; v.mlast = m_tlast; v.mready = m_tready;
      v.busy = busy; v.done = pkt_done; v.mdata = m_tdata; v.gid = grant_id;
      v.beats = pkt_beats; v.cnt = pkt_cnt;
      if (cyc < 1024) smp[cyc] = v;
      if (m_tvaild && m_tready && n_hl < 128) begin
         hl[n_hl].cyc = cyc; hl[n_hl].gid = grant_id; hl[n_hl].d = m_tdata; hl[n_hl].l = m_tlast;
         n_hl++;
      end
      if (pkt_done && n_dl < 32) begin
         dl[n_dl].cyc = cyc; dl[n_dl].beats = pkt_beats; dl[n_dl].cnt = pkt_cnt;
         n_dl++;
      end
      hs = s_tvaild & s_tready;
   endtask

   task automatic update();
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            rd[i]++;
            if (rd[i] < wr[i]) gapc[i] = mem[i][rd[i]].gap;
         end else if (rd[i] < wr[i] && gapc[i] > 0) begin
            gapc[i]--;
         end
      end
   endtask

   // Drive at posedge+1, sample on the falling edge, advance sources after the rising edge.
   task automatic cycle();
      drive();
      #4;
      sample();
      cyc++;
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int k;
      k = 0;
      do begin
         cycle();
         k++;
      end while ((pending() || smp[cyc-1].busy) && k < budget);
      check(tag, {31'b0, pending() | smp[cyc-1].busy}, 0);
   endtask

   task automatic reset_dut(input int n);
      resetn = 1'b0;
      clear_q();
      repeat (n) cycle();
      resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; n_hl = 0; n_dl = 0;
      tog_en = 1'b0; tog_base = 0; hs = '0;
      resetn = 1'b0; m_tready = 1'b1;
      s_tvaild = '0; s_tdata = '0; s_tlast = '0;
      clear_q();
      @(posedge clk);
      #1;

      // 1: reset with every source requesting, then first grant goes to source 0
      for (int s = 0; s < N; s++) push(s, DW'(8'hA0 + s), 1'b1, 0);
      r0 = cyc;
      cycle();
      cycle();
      check("t1 rst s_tready",  smp[r0+1].sready, 0);
      check("t1 rst m_tvaild",  smp[r0+1].mvalid, 0);
      check("t1 rst m_tlast",   smp[r0+1].mlast, 0);
      check("t1 rst m_tdata",   smp[r0+1].mdata, 0);
      check("t1 rst busy",      smp[r0+1].busy, 0);
      check("t1 rst pkt_done",  smp[r0+1].done, 0);
      check("t1 rst pkt_beats", smp[r0+1].beats, 0);
      check("t1 rst pkt_cnt",   smp[r0+1].cnt, 0);
      check("t1 rst grant_id",  smp[r0+1].gid, 0);
      resetn = 1'b1;
      n_hl = 0; n_dl = 0; c0 = cyc;
      drain("t1 drain", 40);
      check("t1 post m_tvaild", smp[c0].mvalid, 0);
      check("t1 post s_tready", smp[c0].sready, 0);
      check("t1 first busy",    smp[c0+1].busy, 1);
      check("t1 first grant",   smp[c0+1].gid, 0);
      check("t1 beats logged",  n_hl, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1 gid %0d", k),  hl[k].gid, k);
         check($sformatf("t1 data %0d", k), hl[k].d, 8'hA0 + k);
         check($sformatf("t1 cyc %0d", k),  hl[k].cyc, c0 + 1 + 2*k);
      end

      // 2: fairness, all sources with two 3-beat packets each
      reset_dut(2);
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < N; s++) push_pkt(s, s*16 + p*4, 3);
      n_hl = 0; n_dl = 0; c0 = cyc;
      drain("t2 drain", 80);
      check("t2 beats logged", n_hl, 24);
      check("t2 pkts done",    n_dl, 8);
      for (int k = 0; k < 8; k++) begin
         for (int b = 0; b < 3; b++) begin
            check($sformatf("t2 gid %0d.%0d", k, b),  hl[3*k+b].gid, k % 4);
            check($sformatf("t2 data %0d.%0d", k, b), hl[3*k+b].d, (k % 4)*16 + (k / 4)*4 + b);
            check($sformatf("t2 last %0d.%0d", k, b), hl[3*k+b].l, (b == 2));
         end
         check($sformatf("t2 start cyc %0d", k), hl[3*k].cyc, c0 + 1 + 4*k);
         check($sformatf("t2 pkt_beats %0d", k), dl[k].beats, 3);
         check($sformatf("t2 pkt_cnt %0d", k),   dl[k].cnt, k + 1);
         check($sformatf("t2 done cyc %0d", k),  dl[k].cyc, c0 + 4 + 4*k);
      end
      check("t2 done pulse width", smp[c0+5].done, 0);

      // 3: src1 5-beat packet with a 2-cycle gap before beat 3 while src2 waits
      n_hl = 0; n_dl = 0;
      push_pkt(1, 8'h50, 5);
      mem[1][wr[1]-3].gap = 2;
      push_pkt(2, 8'h60, 2);
      c0 = cyc;
      drain("t3 drain", 60);
      check("t3 beats logged", n_hl, 7);
      for (int b = 0; b < 5; b++) begin
         check($sformatf("t3 src1 gid %0d", b),  hl[b].gid, 1);
         check($sformatf("t3 src1 data %0d", b), hl[b].d, 8'h50 + b);
      end
      check("t3 beat3 cyc",        hl[2].cyc, c0 + 5);
      check("t3 src1 last cyc",    hl[4].cyc, c0 + 7);
      check("t3 gap busy",         smp[c0+3].busy, 1);
      check("t3 gap grant",        smp[c0+3].gid, 1);
      check("t3 gap m_tvaild",     smp[c0+3].mvalid, 0);
      check("t3 gap s_tready",     smp[c0+3].sready, 4'b0010);
      check("t3 bubble busy",      smp[c0+8].busy, 0);
      check("t3 src2 gid",         hl[5].gid, 2);
      check("t3 src2 data0",       hl[5].d, 8'h60);
      check("t3 src2 data1",       hl[6].d, 8'h61);
      check("t3 src2 first cyc",   hl[5].cyc, c0 + 9);
      check("t3 pkt_beats",        dl[0].beats, 5);

      // 4: backpressure, m_tready toggles 1,0,1,0... from the arbitration cycle
      n_hl = 0; n_dl = 0;
      push_pkt(0, 8'h70, 4);
      push_pkt(1, 8'h80, 1);
      tog_en = 1'b1; tog_base = cyc; c0 = cyc;
      drain("t4 drain", 60);
      tog_en = 1'b0;
      check("t4 beats logged", n_hl, 5);
      for (int b = 0; b < 4; b++) begin
         check($sformatf("t4 gid %0d", b),  hl[b].gid, 0);
         check($sformatf("t4 data %0d", b), hl[b].d, 8'h70 + b);
         check($sformatf("t4 cyc %0d", b),  hl[b].cyc, c0 + 2 + 2*b);
      end
      for (int j = 1; j <= 8; j++)
         check($sformatf("t4 s_tready cyc %0d", j), smp[c0+j].sready,
               (((j % 2) == 0) ? 4'b0001 : 4'b0000));
      check("t4 pkt_beats",     dl[0].beats, 4);
      check("t4 src1 data",     hl[4].d, 8'h80);
      check("t4 src1 cyc",      hl[4].cyc, c0 + 10);
      check("t4 src1 s_tready", smp[c0+10].sready, 4'b0010);

      // 5: sparse single-beat packets from src3 only
      n_hl = 0; n_dl = 0;
      push(3, 8'hC0, 1'b1, 0);
      push(3, 8'hC1, 1'b1, 1);
      push(3, 8'hC2, 1'b1, 1);
      c0 = cyc;
      drain("t5 drain", 40);
      check("t5 beats logged", n_hl, 3);
      check("t5 pkts done",    n_dl, 3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5 gid %0d", k),       hl[k].gid, 3);
         check($sformatf("t5 data %0d", k),      hl[k].d, 8'hC0 + k);
         check($sformatf("t5 cyc %0d", k),       hl[k].cyc, c0 + 1 + 3*k);
         check($sformatf("t5 pkt_beats %0d", k), dl[k].beats, 1);
         check($sformatf("t5 done cyc %0d", k),  dl[k].cyc, c0 + 2 + 3*k);
      end
      check("t5 done pulse width", smp[c0+3].done, 0);

      // 6: reset in the middle of a src2 packet, pointer left at 2 beforehand
      n_hl = 0; n_dl = 0;
      push_pkt(2, 8'hD0, 1);
      drain("t6 pre drain", 20);
      n_hl = 0;
      push_pkt(2, 8'hE0, 4);
      c0 = cyc;
      cycle();
      cycle();
      cycle();
      check("t6 pre busy",  smp[c0+2].busy, 1);
      check("t6 pre beats", n_hl, 2);
      check("t6 pre data",  hl[1].d, 8'hE1);
      resetn = 1'b0;
      clear_q();
      push(0, 8'hF0, 1'b1, 0);
      push(3, 8'hF3, 1'b1, 0);
      r0 = cyc;
      cycle();
      check("t6 rst pkt_cnt",  smp[r0].cnt, 0);
      check("t6 rst busy",     smp[r0].busy, 0);
      check("t6 rst grant",    smp[r0].gid, 0);
      check("t6 rst s_tready", smp[r0].sready, 0);
      check("t6 rst m_tvaild", smp[r0].mvalid, 0);
      check("t6 rst pkt_beats", smp[r0].beats, 0);
      resetn = 1'b1;
      n_hl = 0; n_dl = 0; c1 = cyc;
      drain("t6 drain", 40);
      check("t6 beats logged", n_hl, 2);
      check("t6 first gid",    hl[0].gid, 0);
      check("t6 first data",   hl[0].d, 8'hF0);
      check("t6 first cyc",    hl[0].cyc, c1 + 1);
      check("t6 second gid",   hl[1].gid, 3);
      check("t6 second cyc",   hl[1].cyc, c1 + 3);
      check("t6 pkt_cnt 1",    dl[0].cnt, 1);
      check("t6 pkt_cnt 2",    dl[1].cnt, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
